// File: rtl/llr_pair_loader.sv
// llr_pair_loader
// Channel-LLR front end of the polar decoder. Collects one frame of N LLRs
// from a serial stream into an internal buffer, then presents the N/2
// stage-0 operand pairs (LLR[k], LLR[k+N/2]) to the f/g-node units.
//
// Build option: define LLR_CLAMP_EN to store the most-negative input code
// as (most-negative + 1), so downstream negation can never overflow.
//
// Handshake rule (both ports): a transfer happens on a rising clk edge where
// valid && ready are both high. A producer holding valid keeps its data
// stable until that edge; this block never drops out_valid or changes the
// pair without a transfer.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   in_valid/ready   input LLR stream handshake, in_llr is the LLR
//   out_valid/ready  output pair handshake
//   out_x, out_y     LLR[k], LLR[k+N/2]
//   out_idx          pair index k
//   out_last         high with out_valid on k = N/2-1
//   fsm_state        debug view of the FSM (0 = LOAD, 1 = EMIT)
`ifndef SIZE
`define SIZE 8
`endif

module llr_pair_loader #(
  parameter int N = 8,
  localparam int IW = $clog2(N / 2),
  localparam int WW = IW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [`SIZE-1:0]  in_llr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [`SIZE-1:0]  out_x,
  output logic [`SIZE-1:0]  out_y,
  output logic [IW-1:0]     out_idx,
  output logic              out_last,
  output logic              fsm_state
);

  localparam int SZ = `SIZE;

  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t          state;
  logic [WW-1:0]   wr_cnt;
  logic [IW-1:0]   rd_cnt;
  logic [SZ-1:0]   llr_buf [N];
  logic [SZ-1:0]   store_llr;
  logic            in_hs;
  logic            out_hs;
  logic            rd_at_end;

`ifdef LLR_CLAMP_EN
  localparam logic [SZ-1:0] MOST_NEG = {1'b1, {(SZ - 1){1'b0}}};
  localparam logic [SZ-1:0] CLAMPED  = {1'b1, {(SZ - 2){1'b0}}, 1'b1};
  assign store_llr = (in_llr == MOST_NEG) ? CLAMPED : in_llr;
`else
  assign store_llr = in_llr;
`endif

  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign rd_at_end = (rd_cnt == IW'(N / 2 - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (in_hs) begin
            if (wr_cnt == WW'(N - 1)) begin
              wr_cnt    <= '0;
              rd_cnt    <= '0;
              state     <= EMIT;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              wr_cnt <= wr_cnt + WW'(1);
            end
          end
        end
        EMIT: begin
          if (out_hs) begin
            if (rd_at_end) begin
              rd_cnt    <= '0;
              state     <= LOAD;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
            end else begin
              rd_cnt <= rd_cnt + IW'(1);
            end
          end
        end
        default: begin
          state     <= LOAD;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Frame storage carries no reset: its contents only matter between the
  // N-th write and the last pair read.
  always_ff @(posedge clk) begin
    if (in_hs) begin
      llr_buf[wr_cnt] <= store_llr;
    end
  end

  // N/2 is a power of two, so k and k+N/2 differ only in the top index bit.
  assign out_x     = llr_buf[{1'b0, rd_cnt}];
  assign out_y     = llr_buf[{1'b1, rd_cnt}];
  assign out_idx   = rd_cnt;
  assign out_last  = out_valid && rd_at_end;
  assign fsm_state = state;

endmodule

// File: tb/tb_llr_pair_loader.sv
// Self-checking bench for llr_pair_loader. A frame-level reference model
// (list of accepted LLRs, list of pending pairs) predicts every output.
`ifndef SIZE
`define SIZE 8
`endif

module tb_llr_pair_loader;

  localparam int N  = 8;
  localparam int SZ = `SIZE;
  localparam int IW = $clog2(N / 2);
  localparam int PW = IW + 1 + 2 * SZ;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [SZ-1:0] in_llr = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [SZ-1:0] out_x;
  logic [SZ-1:0] out_y;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          fsm_state;

  llr_pair_loader #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_llr    (in_llr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .fsm_state (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard
  logic [SZ-1:0] ld_q[$];
  logic [PW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_valid_cycles = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [SZ-1:0] stored(input logic [SZ-1:0] v);
    logic [SZ-1:0] r;
    r = v;
`ifdef LLR_CLAMP_EN
    if ($signed(v) == -(2 ** (SZ - 1))) r = SZ'(-(2 ** (SZ - 1)) + 1);
`endif
    return r;
  endfunction

  // Accept one LLR into the model; a full frame turns into N/2 expected pairs.
  function automatic void model_accept(input logic [SZ-1:0] v);
    ld_q.push_back(stored(v));
    if (ld_q.size() == N) begin
      for (int k = 0; k < N / 2; k++)
        exp_q.push_back({IW'(k), (k == N / 2 - 1) ? 1'b1 : 1'b0, ld_q[k], ld_q[k + N / 2]});
      ld_q.delete();
    end
  endfunction

  // One clock cycle: compare outputs at the falling edge, drive inputs for
  // the next rising edge, and advance the model by the handshakes that edge
  // will perform.
  task automatic tick(input logic iv, input logic [SZ-1:0] v, input logic ordy);
    @(negedge clk);
    check("in_ready", in_ready, exp_q.size() == 0);
    check("out_valid", out_valid, exp_q.size() != 0);
    in_valid  = iv;
    in_llr    = v;
    out_ready = ordy;
    if (exp_q.size() != 0) begin
      n_valid_cycles++;
      check("pair", {out_idx, out_last, out_x, out_y}, exp_q[0]);
      if (ordy) void'(exp_q.pop_front());
    end else begin
      check("last_idle", out_last, 1'b0);
      if (iv) model_accept(v);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_idx", out_idx, '0);
    ld_q.delete();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_seq(input int first);
    for (int i = 0; i < N; i++) tick(1'b1, SZ'(first + i), 1'b1);
  endtask

  task automatic drain();
    while (exp_q.size() != 0) tick(1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b1);
  endtask

  logic [SZ-1:0] most_neg;
  logic [SZ-1:0] neg_exp;
  logic [3:0]    stall_pat;

  initial begin
    most_neg  = {1'b1, {(SZ - 1){1'b0}}};
`ifdef LLR_CLAMP_EN
    neg_exp   = most_neg + SZ'(1);
`else
    neg_exp   = most_neg;
`endif
    stall_pat = 4'b1001;

    // reset state
    repeat (2) @(negedge clk);
    check("init_in_ready", in_ready, 1'b1);
    check("init_out_valid", out_valid, 1'b0);
    check("init_out_idx", out_idx, '0);
    rst = 1'b0;

    // frame 1..8, no stalls: out_valid high exactly N/2 cycles
    n_valid_cycles = 0;
    load_seq(1);
    drain();
    check("valid_cycles", 32'(n_valid_cycles), 32'(N / 2));

    // same frame with out_ready toggling 1,0,0,1
    load_seq(1);
    for (int j = 0; j < 3 * N / 2 + 4; j++) tick(1'b0, '0, stall_pat[j % 4]);
    drain();

    // 99 offered during EMIT is ignored; next frame 10..17 starts at (10,14)
    load_seq(1);
    for (int j = 0; j < N / 2; j++) tick(1'b1, SZ'(99), 1'b1);
    load_seq(10);
    @(posedge clk); #1;
    check("frame_after_99_x", out_x, SZ'(10));
    check("frame_after_99_y", out_y, SZ'(14));
    drain();

    // most-negative code and max positive
    tick(1'b1, most_neg, 1'b1);
    tick(1'b1, SZ'(2 ** (SZ - 1) - 1), 1'b1);
    for (int i = 2; i < N; i++) tick(1'b1, SZ'(i), 1'b1);
    @(posedge clk); #1;
    check("clamp_neg", out_x, neg_exp);
    drain();

    // reset after 5 inputs, then a clean frame 20..27
    for (int i = 0; i < 5; i++) tick(1'b1, SZ'(50 + i), 1'b1);
    do_reset();
    load_seq(20);
    @(posedge clk); #1;
    check("post_rst_x", out_x, SZ'(20));
    check("post_rst_y", out_y, SZ'(24));
    drain();

    // reset while pair 2 is on the output
    load_seq(30);
    tick(1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b1);
    do_reset();
    tick(1'b0, '0, 1'b1);
    load_seq(40);
    drain();

    // two back-to-back frames with in_valid and out_ready always high
    for (int j = 0; j < 3 * N; j++) tick(1'b1, SZ'($urandom), 1'b1);
    drain();

    // randomized traffic with random stalls on both sides
    for (int j = 0; j < 1500; j++)
      tick(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, SZ'($urandom),
           ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
